// File: rtl/instr_fetch_sequencer_if.sv
// Connects the fetch sequencer to the program ROM and the execute stage.
// It carries the ROM read port, the instruction issue handshake and the PC redirect.
interface instr_fetch_sequencer_if #(
   parameter int ROM_ADDR_W = 8
);
   logic [ROM_ADDR_W-1:0] rom_address;
   logic [7:0]            data_from_rom;
   logic [31:0]           instruction_out;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  redirect_valid;
   logic [ROM_ADDR_W-1:0] redirect_pc;

   // The master is the sequencer. The slave is the ROM and execute side.
   modport master (
      output rom_address,
      output instruction_out,
      output instr_valid,
      input  data_from_rom,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  rom_address,
      input  instruction_out,
      input  instr_valid,
      output data_from_rom,
      output instr_ready,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Reads four ROM bytes for each instruction and assembles them into a 32-bit word.
// It issues the word over valid/ready and stops on the HALT opcode.
module instr_fetch_sequencer #(
   parameter int                    ROM_ADDR_W  = 8,
   parameter int                    ROM_LATENCY = 1,
   parameter logic [7:0]            HALT_OPCODE = 8'hFF,
   parameter logic [ROM_ADDR_W-1:0] PC_RESET    = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   instr_fetch_sequencer_if.master   bus,
   output logic [ROM_ADDR_W-1:0]     pc,
   output logic                      busy,
   output logic                      halted
);

   localparam int LAT_W = $clog2(ROM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

   state_t                state;
   state_t                state_next;
   logic [ROM_ADDR_W-1:0] pc_next;
   logic [ROM_ADDR_W-1:0] rom_addr;
   logic [ROM_ADDR_W-1:0] rom_addr_next;
   logic [31:0]           instr_word;
   logic [31:0]           instr_word_next;
   logic [23:0]           partial;
   logic [23:0]           partial_next;
   logic [1:0]            byte_cnt;
   logic [1:0]            byte_cnt_next;
   logic [LAT_W-1:0]      wait_cnt;
   logic [LAT_W-1:0]      wait_cnt_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= PC_RESET;
         rom_addr   <= PC_RESET;
         instr_word <= '0;
         partial    <= '0;
         byte_cnt   <= '0;
         wait_cnt   <= '0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         rom_addr   <= rom_addr_next;
         instr_word <= instr_word_next;
         partial    <= partial_next;
         byte_cnt   <= byte_cnt_next;
         wait_cnt   <= wait_cnt_next;
      end
   end

   // Earlier bytes shift left through the partial register, so byte0 ends up in the opcode slot.
   // A redirect leaves stale bytes behind. Exactly three shifts happen before the word is used, so they are pushed out.
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      rom_addr_next   = rom_addr;
      instr_word_next = instr_word;
      partial_next    = partial;
      byte_cnt_next   = byte_cnt;
      wait_cnt_next   = wait_cnt;

      unique case (state)
         IDLE, HALTED: begin
            if (start) begin
               state_next    = FETCH;
               pc_next       = PC_RESET;
               rom_addr_next = PC_RESET;
               byte_cnt_next = '0;
               wait_cnt_next = '0;
            end
         end
         FETCH: begin
            if (bus.redirect_valid) begin
               state_next    = FETCH;
               pc_next       = bus.redirect_pc;
               rom_addr_next = bus.redirect_pc;
               byte_cnt_next = '0;
               wait_cnt_next = '0;
            end else if (wait_cnt == LAT_W'(ROM_LATENCY)) begin
               wait_cnt_next = '0;
               byte_cnt_next = byte_cnt + 2'd1;
               rom_addr_next = rom_addr + ROM_ADDR_W'(1);
               if (byte_cnt == 2'd3) begin
                  if (partial[23:16] == HALT_OPCODE) begin
                     state_next = HALTED;
                  end else begin
                     state_next      = ISSUE;
                     instr_word_next = {partial, bus.data_from_rom};
                  end
               end else begin
                  partial_next = {partial[15:0], bus.data_from_rom};
               end
            end else begin
               wait_cnt_next = wait_cnt + LAT_W'(1);
            end
         end
         ISSUE: begin
            // When a redirect arrives in the same cycle as a handshake, the handshake still completes.
            // The next PC comes from the redirect.
            if (bus.redirect_valid) begin
               state_next    = FETCH;
               pc_next       = bus.redirect_pc;
               rom_addr_next = bus.redirect_pc;
               byte_cnt_next = '0;
               wait_cnt_next = '0;
            end else if (bus.instr_ready) begin
               state_next    = FETCH;
               pc_next       = pc + ROM_ADDR_W'(4);
               rom_addr_next = pc + ROM_ADDR_W'(4);
               byte_cnt_next = '0;
               wait_cnt_next = '0;
            end
         end
      endcase
   end

   assign bus.rom_address     = rom_addr;
   assign bus.instruction_out = instr_word;
   assign bus.instr_valid     = (state == ISSUE);
   assign busy                = (state == FETCH) || (state == ISSUE);
   assign halted              = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer. Expected words are computed by walking a byte-array ROM.
// A negedge monitor checks every issued instruction against the queue.
module tb_instr_fetch_sequencer;

   typedef struct {
      logic [31:0] word;
      logic [7:0]  addr;
   } issue_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] pc;
   logic       busy;
   logic       halted;
   logic [7:0] rom [256];

   issue_t exp_q [$];
   issue_t mon_e;
   int     checks   = 0;
   int     failures = 0;
   int     hs_count = 0;

   instr_fetch_sequencer_if #(.ROM_ADDR_W(8)) bus_if ();

   instr_fetch_sequencer #(
      .ROM_ADDR_W (8),
      .ROM_LATENCY(1),
      .HALT_OPCODE(8'hFF),
      .PC_RESET   (8'h00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus_if),
      .pc    (pc),
      .busy  (busy),
      .halted(halted)
   );

   always #5 clk = ~clk;

   // The ROM has a single cycle of read latency.
   always @(posedge clk) bus_if.data_from_rom <= rom[bus_if.rom_address];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic report_timeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout expected=event", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_at(input logic [7:0] a);
      logic [7:0] a1, a2, a3;
      a1 = a + 8'd1;
      a2 = a + 8'd2;
      a3 = a + 8'd3;
      return {rom[a], rom[a1], rom[a2], rom[a3]};
   endfunction

   // Walks the program from a given address until it reaches HALT or max_words words.
   // When do_push is set, each word is also queued as an expected issue.
   task automatic push_run(input logic [7:0] from, input int max_words, input bit do_push,
                           output int n, output logic [7:0] stop_pc);
      logic [7:0]  a;
      logic [31:0] w;
      a = from;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         w = word_at(a);
         if (w[31:24] == 8'hFF || n >= max_words) break;
         if (do_push) exp_q.push_back('{word: w, addr: a});
         n++;
         a = a + 8'd4;
      end
      stop_pc = a;
   endtask

   task automatic apply_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_halted(input string name);
      for (int i = 0; i < 2000 && halted !== 1'b1; i++) tick();
      if (halted !== 1'b1) report_timeout(name);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 2000 && bus_if.instr_valid !== 1'b1; i++) tick();
      if (bus_if.instr_valid !== 1'b1) report_timeout(name);
   endtask

   task automatic check_halted_state(input string name, input logic [7:0] exp_pc);
      check_output({name, "_halted"}, 32'(halted), 32'd1);
      check_output({name, "_busy"}, 32'(busy), 32'd0);
      check_output({name, "_valid"}, 32'(bus_if.instr_valid), 32'd0);
      check_output({name, "_pc"}, 32'(pc), 32'(exp_pc));
      check_output({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // The monitor watches for a handshake, which completes at the next rising edge.
   always @(negedge clk) begin
      if (reset === 1'b1 && bus_if.instr_valid === 1'b1 && bus_if.instr_ready === 1'b1) begin
         hs_count++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_issue actual=%h expected=none", bus_if.instruction_out);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("issue_word", bus_if.instruction_out, mon_e.word);
            check_output("issue_pc", 32'(pc), 32'(mon_e.addr));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         n;
      int         n0;
      int         k;
      int         base;
      int         h;
      int         h2;
      int         i;
      logic [7:0] tgt;
      logic [7:0] slot;
      logic [7:0] stop_pc;
      logic [7:0] dummy_pc;

      for (int a = 0; a < 256; a++) rom[a] = 8'h00;
      rom[8'h00] = 8'h12; rom[8'h01] = 8'h34; rom[8'h02] = 8'h56; rom[8'h03] = 8'h78;
      rom[8'h04] = 8'hFF; rom[8'h06] = 8'hFF;
      rom[8'h20] = 8'hDE; rom[8'h21] = 8'hAD; rom[8'h22] = 8'hBE; rom[8'h23] = 8'hEF;
      rom[8'h24] = 8'hFF;
      rom[8'hFE] = 8'hAB; rom[8'hFF] = 8'hCD;

      reset = 1'b0;
      start = 1'b1;
      bus_if.instr_ready    = 1'b0;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_pc    = 8'h00;
      repeat (4) tick();
      check_output("reset_valid", 32'(bus_if.instr_valid), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_halted", 32'(halted), 32'd0);
      check_output("reset_pc", 32'(pc), 32'd0);
      check_output("reset_rom_address", 32'(bus_if.rom_address), 32'd0);
      check_output("reset_instruction", bus_if.instruction_out, 32'd0);
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_output("idle_busy", 32'(busy), 32'd0);

      $display("[TB] single fetch, latency and backpressure");
      apply_start();
      n = 0;
      while (bus_if.instr_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check_output("first_valid_latency", 32'(n), 32'd8);
      for (int c = 0; c < 5; c++) begin
         tick();
         check_output("stall_valid", 32'(bus_if.instr_valid), 32'd1);
         check_output("stall_word", bus_if.instruction_out, 32'h12345678);
         check_output("stall_pc", 32'(pc), 32'd0);
         check_output("stall_rom_address", 32'(bus_if.rom_address), 32'd4);
      end
      exp_q.push_back('{word: 32'h12345678, addr: 8'h00});
      bus_if.instr_ready = 1'b1;
      wait_halted("halt_after_first");
      check_halted_state("halt1", 8'h04);
      check_output("halt_keeps_word", bus_if.instruction_out, 32'h12345678);

      $display("[TB] restart and mid-fetch redirect");
      apply_start();
      check_output("restart_halted", 32'(halted), 32'd0);
      check_output("restart_busy", 32'(busy), 32'd1);
      check_output("restart_pc", 32'(pc), 32'd0);
      tick();
      tick();
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 8'h20;
      exp_q.push_back('{word: 32'hDEADBEEF, addr: 8'h20});
      tick();
      bus_if.redirect_valid = 1'b0;
      check_output("redirect_pc", 32'(pc), 32'h20);
      wait_halted("halt_after_redirect");
      check_halted_state("halt2", 8'h24);

      $display("[TB] redirect with accept and address wrap");
      bus_if.instr_ready = 1'b0;
      apply_start();
      wait_valid("valid_before_wrap");
      bus_if.instr_ready    = 1'b1;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 8'hFE;
      exp_q.push_back('{word: 32'h12345678, addr: 8'h00});
      exp_q.push_back('{word: 32'hABCD1234, addr: 8'hFE});
      exp_q.push_back('{word: 32'h5678FF00, addr: 8'h02});
      tick();
      bus_if.redirect_valid = 1'b0;
      check_output("redirect_accept_pc", 32'(pc), 32'hFE);
      check_output("redirect_accept_rom_address", 32'(bus_if.rom_address), 32'hFE);
      check_output("redirect_accept_valid", 32'(bus_if.instr_valid), 32'd0);
      wait_halted("halt_after_wrap");
      check_halted_state("halt3", 8'h06);

      $display("[TB] randomized programs");
      for (int iter = 0; iter < 20; iter++) begin
         for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(0, 254));
         h = $urandom_range(0, 5);
         slot = 8'(4 * h);
         rom[slot] = 8'hFF;
         tgt = 8'($urandom_range(0, 255));
         h2 = $urandom_range(0, 5);
         slot = tgt + 8'(4 * h2);
         rom[slot] = 8'hFF;
         push_run(8'h00, 64, 1'b0, n0, dummy_pc);
         bus_if.instr_ready = 1'b0;
         base = hs_count;
         if (n0 > 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, n0 - 1);
            push_run(8'h00, k, 1'b1, n, dummy_pc);
            apply_start();
            i = 0;
            while (hs_count - base < k && i < 2000) begin
               bus_if.instr_ready = 1'($urandom_range(0, 1));
               tick();
               i++;
            end
            if (hs_count - base < k) report_timeout("random_pre_redirect");
            bus_if.instr_ready = 1'b0;
            repeat ($urandom_range(0, 12)) tick();
            bus_if.redirect_valid = 1'b1;
            bus_if.redirect_pc    = tgt;
            push_run(tgt, 64, 1'b1, n, stop_pc);
            tick();
            bus_if.redirect_valid = 1'b0;
         end else begin
            push_run(8'h00, 64, 1'b1, n, stop_pc);
            apply_start();
         end
         i = 0;
         while (halted !== 1'b1 && i < 3000) begin
            bus_if.instr_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
         end
         if (halted !== 1'b1) report_timeout("random_halt");
         check_halted_state("random_end", stop_pc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
